// File: rtl/mem_arbiter_if.sv
// Mem_ift: read/write request and reply channels,
// each a valid/ready/bits handshake.
interface Mem_ift #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    r_request_valid;
  logic                    r_request_ready;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    r_reply_valid;
  logic                    r_reply_ready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    w_request_valid;
  logic                    w_request_ready;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    w_reply_valid;
  logic                    w_reply_ready;
  logic [1:0]              bresp;

  modport Master (
    output r_request_valid, raddr, r_reply_ready,
    output w_request_valid, waddr, wdata, wmask,
    output w_reply_ready,
    input  r_request_ready, r_reply_valid, rdata, rresp,
    input  w_request_ready, w_reply_valid, bresp
  );

  modport Slave (
    input  r_request_valid, raddr, r_reply_ready,
    input  w_request_valid, waddr, wdata, wmask,
    input  w_reply_ready,
    output r_request_ready, r_reply_valid, rdata, rresp,
    output w_request_ready, w_reply_valid, bresp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one memory port, one transaction in flight.
// MEM_ARBITER_FIXED_PRIO_EN: m0 always wins contention (else round-robin).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic   clk,
  input  logic   rstn,
  Mem_ift.Slave  m0,
  Mem_ift.Slave  m1,
  Mem_ift.Master mem
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RRESP = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t state;
  logic   grant_id;
  logic   op_wr;
  logic   prio;

  logic req0, req1;
  logic win, win_rd;
  logic next_prio;
  logic req_ph, rsp_ph;
  logic rq, wq, rr, wr;

  logic [ADDR_WIDTH-1:0]   sel_raddr;
  logic [ADDR_WIDTH-1:0]   sel_waddr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wmask;

  assign req0 = m0.r_request_valid | m0.w_request_valid;
  assign req1 = m1.r_request_valid | m1.w_request_valid;

  // Pick the winner among current requesters.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 & req1:  win = prio;
      req1 & ~req0: win = 1'b1;
      default:      win = 1'b0;
    endcase
  end

  // Reads go ahead of a simultaneous write from the same master.
  assign win_rd = win ? m1.r_request_valid
                      : m0.r_request_valid;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign next_prio = 1'b0;
`else
  assign next_prio = ~grant_id;
`endif

  // Grant / transaction sequencing and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      op_wr    <= 1'b0;
      prio     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant_id <= win;
            op_wr    <= ~win_rd;
            state    <= win_rd ? RREQ : WREQ;
          end
        end
        RREQ: begin
          if (mem.r_request_valid && mem.r_request_ready)
            state <= RRESP;
        end
        RRESP: begin
          if (mem.r_reply_valid && mem.r_reply_ready) begin
            state <= IDLE;
            prio  <= next_prio;
          end
        end
        WREQ: begin
          if (mem.w_request_valid && mem.w_request_ready)
            state <= WRESP;
        end
        WRESP: begin
          if (mem.w_reply_valid && mem.w_reply_ready) begin
            state <= IDLE;
            prio  <= next_prio;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ph = (state == RREQ) | (state == WREQ);
  assign rsp_ph = (state == RRESP) | (state == WRESP);
  assign rq     = req_ph & ~op_wr;
  assign wq     = req_ph & op_wr;
  assign rr     = rsp_ph & ~op_wr;
  assign wr     = rsp_ph & op_wr;

  assign sel_raddr = grant_id ? m1.raddr : m0.raddr;
  assign sel_waddr = grant_id ? m1.waddr : m0.waddr;
  assign sel_wdata = grant_id ? m1.wdata : m0.wdata;
  assign sel_wmask = grant_id ? m1.wmask : m0.wmask;

  assign mem.raddr = sel_raddr;
  assign mem.waddr = sel_waddr;
  assign mem.wdata = sel_wdata;
  assign mem.wmask = sel_wmask;

  assign mem.r_request_valid = rq &
    (grant_id ? m1.r_request_valid : m0.r_request_valid);
  assign mem.w_request_valid = wq &
    (grant_id ? m1.w_request_valid : m0.w_request_valid);
  assign mem.r_reply_ready = rr &
    (grant_id ? m1.r_reply_ready : m0.r_reply_ready);
  assign mem.w_reply_ready = wr &
    (grant_id ? m1.w_reply_ready : m0.w_reply_ready);

  assign m0.r_request_ready = rq & ~grant_id & mem.r_request_ready;
  assign m1.r_request_ready = rq &  grant_id & mem.r_request_ready;
  assign m0.w_request_ready = wq & ~grant_id & mem.w_request_ready;
  assign m1.w_request_ready = wq &  grant_id & mem.w_request_ready;

  assign m0.r_reply_valid = rr & ~grant_id & mem.r_reply_valid;
  assign m1.r_reply_valid = rr &  grant_id & mem.r_reply_valid;
  assign m0.w_reply_valid = wr & ~grant_id & mem.w_reply_valid;
  assign m1.w_reply_valid = wr &  grant_id & mem.w_reply_valid;

  // Reply bits are broadcast; only the valids are steered.
  assign m0.rdata = mem.rdata;
  assign m1.rdata = mem.rdata;
  assign m0.rresp = mem.rresp;
  assign m1.rresp = mem.rresp;
  assign m0.bresp = mem.bresp;
  assign m1.bresp = mem.bresp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted masters, a memory responder
// and a scoreboard of expected grants and replies.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m0_if ();
  Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m1_if ();
  Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mem_if ();

  mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .m0   (m0_if),
    .m1   (m1_if),
    .mem  (mem_if)
  );

  logic        rv  [2];
  logic        wv  [2];
  logic        rrd [2];
  logic        wrd [2];
  logic [63:0] ra  [2];
  logic [63:0] wa  [2];
  logic [63:0] wd  [2];
  logic [7:0]  wm  [2];

  assign m0_if.r_request_valid = rv[0];
  assign m0_if.raddr           = ra[0];
  assign m0_if.r_reply_ready   = rrd[0];
  assign m0_if.w_request_valid = wv[0];
  assign m0_if.waddr           = wa[0];
  assign m0_if.wdata           = wd[0];
  assign m0_if.wmask           = wm[0];
  assign m0_if.w_reply_ready   = wrd[0];
  assign m1_if.r_request_valid = rv[1];
  assign m1_if.raddr           = ra[1];
  assign m1_if.r_reply_ready   = rrd[1];
  assign m1_if.w_request_valid = wv[1];
  assign m1_if.waddr           = wa[1];
  assign m1_if.wdata           = wd[1];
  assign m1_if.wmask           = wm[1];
  assign m1_if.w_reply_ready   = wrd[1];

  logic [1:0]  rq_rdy, wq_rdy, rp_vld, wp_vld;
  logic [63:0] rd_o [2];
  logic [1:0]  rr_o [2];
  logic [1:0]  br_o [2];

  assign rq_rdy  = {m1_if.r_request_ready, m0_if.r_request_ready};
  assign wq_rdy  = {m1_if.w_request_ready, m0_if.w_request_ready};
  assign rp_vld  = {m1_if.r_reply_valid, m0_if.r_reply_valid};
  assign wp_vld  = {m1_if.w_reply_valid, m0_if.w_reply_valid};
  assign rd_o[0] = m0_if.rdata;
  assign rd_o[1] = m1_if.rdata;
  assign rr_o[0] = m0_if.rresp;
  assign rr_o[1] = m1_if.rresp;
  assign br_o[0] = m0_if.bresp;
  assign br_o[1] = m1_if.bresp;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h1000) return 64'h0123456789ABCDEF;
    return {~a[31:0], a[31:0]};
  endfunction

  typedef struct {
    int          id;
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic [1:0]  resp;
  } txn_t;

  txn_t exp_req[$];
  txn_t exp_rsp[$];

  function automatic void push_rd(input int id, input logic [63:0] a);
    txn_t t;
    t.id = id; t.w = 1'b0; t.a = a;
    t.d = mem_data(a); t.m = 8'h0; t.resp = a[5:4];
    exp_req.push_back(t);
    exp_rsp.push_back(t);
  endfunction

  function automatic void push_wr(input int id, input logic [63:0] a,
                                  input logic [63:0] d,
                                  input logic [7:0] m);
    txn_t t;
    t.id = id; t.w = 1'b1; t.a = a;
    t.d = d; t.m = m; t.resp = a[5:4];
    exp_req.push_back(t);
    exp_rsp.push_back(t);
  endfunction

  // Memory responder knobs
  int req_stall   = 0;
  int rsp_dly     = 2;
  int rsp_wait    = 300;
  bit expect_drop = 1'b0;

  initial begin
    mem_if.r_request_ready = 1'b0;
    mem_if.w_request_ready = 1'b0;
    mem_if.r_reply_valid   = 1'b0;
    mem_if.w_reply_valid   = 1'b0;
    mem_if.rdata           = 64'h0;
    mem_if.rresp           = 2'b0;
    mem_if.bresp           = 2'b0;
    forever begin
      @(posedge clk); #1;
      if (rstn && (mem_if.r_request_valid ||
                   mem_if.w_request_valid)) begin
        bit          w;
        bit          got;
        logic [63:0] a;
        int          t;
        w = mem_if.w_request_valid;
        a = w ? mem_if.waddr : mem_if.raddr;
        repeat (req_stall) begin @(posedge clk); #1; end
        if (w) mem_if.w_request_ready = 1'b1;
        else   mem_if.r_request_ready = 1'b1;
        @(posedge clk); #1;
        mem_if.w_request_ready = 1'b0;
        mem_if.r_request_ready = 1'b0;
        repeat (rsp_dly - 1) begin @(posedge clk); #1; end
        if (w) begin
          mem_if.bresp = a[5:4];
          mem_if.w_reply_valid = 1'b1;
        end else begin
          mem_if.rdata = mem_data(a);
          mem_if.rresp = a[5:4];
          mem_if.r_reply_valid = 1'b1;
        end
        t = 0;
        got = 1'b0;
        while (!got && t < rsp_wait) begin
          @(negedge clk);
          t++;
          got = w ? mem_if.w_reply_ready : mem_if.r_reply_ready;
        end
        if (!got && !expect_drop) chk("mem_rsp_timeout", 1, 0);
        @(posedge clk); #1;
        mem_if.r_reply_valid = 1'b0;
        mem_if.w_reply_valid = 1'b0;
      end
    end
  end

  int          hs_rq = 0;
  int          hs_wq = 0;
  int          hs_rp [2] = '{0, 0};
  bit          pend_r = 1'b0;
  bit          pend_p = 1'b0;
  logic [63:0] last_ra = '0;
  logic [63:0] last_rd = '0;

  task automatic req_event(input bit w);
    txn_t e;
    logic id;
    id = w ? wq_rdy[1] : rq_rdy[1];
    if (exp_req.size() == 0) begin
      chk("unexp_req", 1, 0);
    end else begin
      e = exp_req.pop_front();
      chk("req_kind", 64'(w), 64'(e.w));
      chk("req_id", 64'(id), 64'(e.id));
      chk("req_addr", w ? mem_if.waddr : mem_if.raddr, e.a);
      if (w) begin
        chk("req_wdata", mem_if.wdata, e.d);
        chk("req_wmask", 64'(mem_if.wmask), 64'(e.m));
      end
    end
  endtask

  task automatic rsp_event(input int i, input bit w);
    txn_t e;
    hs_rp[i]++;
    chk("rsp_other_quiet",
        64'(rp_vld[1-i] | wp_vld[1-i]), 0);
    if (exp_rsp.size() == 0) begin
      chk("unexp_rsp", 1, 0);
    end else begin
      e = exp_rsp.pop_front();
      chk("rsp_kind", 64'(w), 64'(e.w));
      chk("rsp_id", 64'(i), 64'(e.id));
      if (w) begin
        chk("rsp_bresp", 64'(br_o[i]), 64'(e.resp));
      end else begin
        chk("rsp_rdata", rd_o[i], e.d);
        chk("rsp_rresp", 64'(rr_o[i]), 64'(e.resp));
      end
    end
  endtask

  // Handshake monitor: sample between edges, pop the scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      pend_r = 1'b0;
      pend_p = 1'b0;
    end else begin
      if (pend_r && mem_if.r_request_valid)
        chk("rq_addr_stable", mem_if.raddr, last_ra);
      if (pend_p && rp_vld[0])
        chk("rp_data_stable", rd_o[0], last_rd);
      pend_r  = mem_if.r_request_valid & ~mem_if.r_request_ready;
      last_ra = mem_if.raddr;
      pend_p  = rp_vld[0] & ~rrd[0];
      last_rd = rd_o[0];
      if (mem_if.r_request_valid && mem_if.r_request_ready) begin
        hs_rq++;
        req_event(1'b0);
      end
      if (mem_if.w_request_valid && mem_if.w_request_ready) begin
        hs_wq++;
        req_event(1'b1);
      end
      for (int i = 0; i < 2; i++) begin
        if (rp_vld[i] && rrd[i]) rsp_event(i, 1'b0);
        if (wp_vld[i] && wrd[i]) rsp_event(i, 1'b1);
      end
    end
  end

  task automatic mread(input int id, input logic [63:0] a,
                       input int hold);
    int t;
    ra[id] = a;
    rv[id] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!rq_rdy[id] && t < 300);
    if (!rq_rdy[id]) chk("rreq_timeout", 1, 0);
    @(posedge clk); #1;
    rv[id] = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    rrd[id] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!rp_vld[id] && t < 300);
    if (!rp_vld[id]) chk("rrsp_timeout", 1, 0);
    @(posedge clk); #1;
    rrd[id] = 1'b0;
  endtask

  task automatic mwrite(input int id, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    int t;
    wa[id] = a;
    wd[id] = d;
    wm[id] = m;
    wv[id] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!wq_rdy[id] && t < 300);
    if (!wq_rdy[id]) chk("wreq_timeout", 1, 0);
    @(posedge clk); #1;
    wv[id] = 1'b0;
    wrd[id] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!wp_vld[id] && t < 300);
    if (!wp_vld[id]) chk("wrsp_timeout", 1, 0);
    @(posedge clk); #1;
    wrd[id] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int b_rq, b_rp0, b_rp1, t;
    bit saw_vld, saw_rdy;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; wv[i] = 0; rrd[i] = 0; wrd[i] = 0;
      ra[i] = 0; wa[i] = 0; wd[i] = 0; wm[i] = 0;
    end

    // Reset: outputs quiet even with requests pending
    cycles(2);
    rv[0] = 1'b1;
    ra[0] = 64'h1000;
    wv[1] = 1'b1;
    cycles(2);
    chk("rst_mem_out", 64'({mem_if.r_request_valid,
        mem_if.w_request_valid, mem_if.r_reply_ready,
        mem_if.w_reply_ready}), 0);
    chk("rst_master_out",
        64'({rq_rdy, wq_rdy, rp_vld, wp_vld}), 0);
    chk("rst_state", 64'(dut.state), 0);
    chk("rst_prio", 64'(dut.prio), 0);
    chk("rst_grant", 64'({dut.grant_id, dut.op_wr}), 0);
    rv[0] = 1'b0;
    wv[1] = 1'b0;
    cycles(1);
    rstn = 1'b1;

    // Single read from m0
    b_rp1 = hs_rp[1];
    push_rd(0, 64'h1000);
    mread(0, 64'h1000, 0);
    cycles(2);
    chk("single_m1_quiet", 64'(hs_rp[1] - b_rp1), 0);
    chk("single_idle", 64'(dut.state), 0);

    // Reset while the reply is outstanding (prio is 1 here)
    expect_drop = 1'b1;
    rsp_dly = 4;
    rsp_wait = 8;
    b_rq = hs_rq;
    b_rp0 = hs_rp[0];
    exp_req.push_back('{0, 1'b0, 64'h1040, 64'h0, 8'h0, 2'b0});
    ra[0] = 64'h1040;
    rv[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!rq_rdy[0] && t < 50);
    if (!rq_rdy[0]) chk("abort_req_timeout", 1, 0);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    rrd[0] = 1'b1;
    cycles(1);
    chk("abort_in_rresp", 64'(dut.state), 2);
    chk("abort_prio_before", 64'(dut.prio), 1);
    rstn = 1'b0;
    #1;
    chk("abort_state_now", 64'(dut.state), 0);
    chk("abort_prio_now", 64'(dut.prio), 0);
    cycles(1);
    rstn = 1'b1;
    saw_vld = 1'b0;
    saw_rdy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_vld |= rp_vld[0] | rp_vld[1];
      saw_rdy |= mem_if.r_reply_ready;
    end
    chk("abort_no_fwd", 64'(saw_vld), 0);
    chk("abort_no_mem_rdy", 64'(saw_rdy), 0);
    chk("abort_rsp_count", 64'(hs_rp[0] - b_rp0), 0);
    chk("abort_req_count", 64'(hs_rq - b_rq), 1);
    chk("abort_idle", 64'(dut.state), 0);
    chk("abort_prio", 64'(dut.prio), 0);
    @(posedge clk); #1;
    rrd[0] = 1'b0;
    expect_drop = 1'b0;
    rsp_dly = 2;
    rsp_wait = 300;

    // Contention: both read continuously from prio=0
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    push_rd(0, 64'h100);
    push_rd(0, 64'h140);
    push_rd(0, 64'h180);
    push_rd(0, 64'h1C0);
    push_rd(1, 64'h200);
    push_rd(1, 64'h240);
`else
    push_rd(0, 64'h100);
    push_rd(1, 64'h200);
    push_rd(0, 64'h140);
    push_rd(1, 64'h240);
    push_rd(0, 64'h180);
    push_rd(0, 64'h1C0);
`endif
    fork
      begin
        mread(0, 64'h100, 0);
        mread(0, 64'h140, 0);
        mread(0, 64'h180, 0);
        mread(0, 64'h1C0, 0);
      end
      begin
        mread(1, 64'h200, 0);
        mread(1, 64'h240, 0);
      end
    join
    cycles(2);

    // Same-cycle read and write from m1: read first
    b_rq = hs_rq;
    push_rd(1, 64'h2030);
    push_wr(1, 64'h2000, 64'hFF, 8'h01);
    fork
      mread(1, 64'h2030, 0);
      mwrite(1, 64'h2000, 64'hFF, 8'h01);
    join
    cycles(2);
    chk("rw_write_count", 64'(hs_wq), 1);
    chk("rw_read_count", 64'(hs_rq - b_rq), 1);

    // Backpressure on both mem request and m0 reply
    req_stall = 5;
    b_rq = hs_rq;
    b_rp0 = hs_rp[0];
    push_rd(0, 64'h1010);
    mread(0, 64'h1010, 5);
    cycles(4);
    chk("bp_req_once", 64'(hs_rq - b_rq), 1);
    chk("bp_rsp_once", 64'(hs_rp[0] - b_rp0), 1);
    req_stall = 0;

    cycles(3);
    chk("exp_req_left", 64'(exp_req.size()), 0);
    chk("exp_rsp_left", 64'(exp_rsp.size()), 0);
    chk("end_idle", 64'(dut.state), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
